demux_router_reg: RTL and testbench
===================================

Name: demux_router_reg

Overview:
- Parametrised, registered successor to the combinational 8-line 8-bit demux in the SAP datapath.
- Routes one input word to one of CHANNELS per-channel holding registers, or to all of them (broadcast).
- Uses a valid/ready handshake on the input and on every output.
- Each output register keeps its last value after it is consumed (SAP output-latch semantics). Undeliverable selects are dropped and counted.

Parameters:
- WIDTH, 8, data word width in bits.
- CHANNELS, 8, number of output channels (2..16).
- SEL_W, $clog2(CHANNELS), select width (derived; do not override).
- CNT_W, 8, width of the drop counter.

Ports:
- clk  in  1  system clock, rising edge.
- clr_n  in  1  asynchronous active-low reset.
- in_data  in  WIDTH  word to route.
- in_sel  in  SEL_W  destination channel index.
- in_bcast  in  1  1 = write all channels; in_sel is ignored.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept this cycle (combinational).
- out_data  out  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]; registered.
- out_valid  out  CHANNELS  channel i holds an unconsumed word.
- out_ready  in  CHANNELS  consumer of channel i accepts.
- drop_count  out  CNT_W  saturating count of dropped words.
- busy  out  1  OR of out_valid.

Behaviour:
- Reset: asynchronous on clr_n low. out_data=0, out_valid=0, drop_count=0, busy=0. A word in flight at reset is lost.
- Accept: accept = in_valid & in_ready, sampled on the rising edge of clk.
- Per-channel free term: free[i] = !out_valid[i] | out_ready[i]. A drain and a refill in the same cycle are allowed.
- in_ready, broadcast (in_bcast=1): AND of free[i] over all channels.
- in_ready, unicast with in_sel < CHANNELS: free[in_sel].
- in_ready, unicast with in_sel >= CHANNELS: 1. The word is accepted and dropped; drop_count increments and saturates at all-ones.
- in_ready must not depend on in_valid. It depends combinationally on out_ready, in_sel and in_bcast.
- Load: on accept, each targeted channel gets out_data[i] <= in_data and out_valid[i] <= 1. Latency is 1 cycle from accept to out_valid.
- Drain: out_valid[i] & out_ready[i] with no same-cycle load clears out_valid[i] on the next edge. out_data[i] keeps its value.
- Simultaneous drain and load on the same channel: out_valid stays 1, out_data takes the new word. No bubble.
- Untargeted channels are unaffected by an accept.
- out_ready on a channel with out_valid=0 has no effect.
- Broadcast is all-or-nothing. It stalls while any channel is full and not draining; no partial writes.
- When CHANNELS is not a power of two, select values in the range CHANNELS..2^SEL_W-1 take the drop path.
- Throughput: one word per cycle when the destinations are free.

Decomposition:
- Shared SAP header/package holds:
  - default WIDTH constant;
  - a clog2-based select-width helper;
  - the saturating-increment function used by drop_count.
- One sub-module: demux_chan_slot, a one-entry holding register with load/drain/valid logic and retained data. Instantiate CHANNELS times with a generate loop.
- Routing decode, broadcast AND-reduce and the drop counter stay in the top module.

Test Plan:
- Reset: drive clr_n=0 mid-stream with out_valid=8'h05 → all out_valid=0, out_data=0 and drop_count=0 asynchronously, before the next clk edge.
- Unicast sweep: in_data=7, in_sel=0..7 one per cycle, all out_ready=0 → out_valid bit i rises one cycle after accept; each channel reads 8'h07. Then in_sel=3 again → in_ready=0, ch3 keeps its word.
- Drain and refill: ch2 holds 8'hA5; in the same cycle assert out_ready[2]=1 and send in_sel=2, in_data=8'h3C → in_ready=1, next cycle out_valid[2]=1 and out_data ch2=8'h3C.
- Retain: ch4 holds 8'h11, pulse out_ready[4] → out_valid[4]=0, out_data ch4 still 8'h11.
- Broadcast stall:
  - ch5 full with out_ready[5]=0, in_bcast=1, in_data=8'hFF → in_ready=0 and no channel changes.
  - Raise out_ready[5] → accept; all 8 channels read 8'hFF with out_valid=8'hFF.
- Drop path: CHANNELS=6 instance, in_sel=7 for 300 consecutive cycles → in_ready=1 throughout, no out_valid change, drop_count saturates at 255.

Source files
------------

// File: rtl/demux_router_reg_pkg.sv
// demux_router_reg_pkg: shared constants and helpers for the registered demux router
package demux_router_reg_pkg;
  localparam int DEF_WIDTH = 8;

  function automatic int sel_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v >= max) ? max : v + 32'd1;
  endfunction
endpackage

// File: rtl/demux_router_reg_chan_slot.sv
// demux_chan_slot: one-entry output holding register that keeps its data after it is consumed
module demux_chan_slot
  import demux_router_reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_free
);
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  // load wins over drain so a same-cycle drain and refill leaves no bubble
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (i_load) r_data <= i_data;
      r_valid <= i_load | (r_valid & ~i_ready);
    end
  end
  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_free  = ~r_valid | i_ready;
endmodule

// File: rtl/demux_router_reg.sv
// demux_router_reg: routes a word to one or all channel registers with valid/ready and drop counting
module demux_router_reg
  import demux_router_reg_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = sel_width(CHANNELS),
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      clr_n,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_bcast,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [CNT_W-1:0]          drop_count,
  output logic                      busy
);
  localparam int SEL_N = 1 << SEL_W;
  localparam logic [SEL_W:0] LP_CH = (SEL_W + 1)'(CHANNELS);
  logic [CHANNELS-1:0] w_free;
  logic [CHANNELS-1:0] w_load;
  logic [SEL_N-1:0]    w_free_ext;
  logic                w_in_range;
  logic                w_accept;
  logic                w_drop;
  logic [CNT_W-1:0]    r_drop_count;

  assign w_in_range = {1'b0, in_sel} < LP_CH;
  assign w_free_ext = SEL_N'(w_free);
  assign in_ready   = in_bcast ? &w_free : (w_in_range ? w_free_ext[in_sel] : 1'b1);
  assign w_accept   = in_valid & in_ready;
  assign w_drop     = w_accept & ~in_bcast & ~w_in_range;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    assign w_load[i] = w_accept & (in_bcast | (in_sel == SEL_W'(i)));
    demux_chan_slot #(.WIDTH(WIDTH)) u_slot (
      .clk     (clk),
      .clr_n   (clr_n),
      .i_load  (w_load[i]),
      .i_data  (in_data),
      .i_ready (out_ready[i]),
      .o_data  (out_data[i*WIDTH +: WIDTH]),
      .o_valid (out_valid[i]),
      .o_free  (w_free[i])
    );
  end

  // count words accepted for a select with no channel, saturating at all-ones
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) r_drop_count <= '0;
    else if (w_drop) r_drop_count <= CNT_W'(sat_inc(32'(r_drop_count), 32'({CNT_W{1'b1}})));
  end

  assign drop_count = r_drop_count;
  assign busy       = |out_valid;
endmodule

// File: tb/tb_demux_router_reg.sv
// tb_demux_router_reg: scoreboard bench for the 8-channel router and a 6-channel drop-path instance
module tb_demux_router_reg;
  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic [7:0]  in_data = '0;
  logic [2:0]  in_sel = '0;
  logic        in_bcast = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] out_data;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready = '0;
  logic [7:0]  drop_count;
  logic        busy;

  logic [7:0]  d6_data = '0;
  logic [2:0]  d6_sel = '0;
  logic        d6_bcast = 1'b0;
  logic        d6_valid = 1'b0;
  logic        d6_ready;
  logic [47:0] d6_out_data;
  logic [5:0]  d6_out_valid;
  logic [5:0]  d6_out_ready = '0;
  logic [7:0]  d6_drop;
  logic        d6_busy;

  typedef struct {int ch; logic [7:0] d;} sb_t;
  sb_t         sb[$];
  logic [7:0]  m_valid = '0;
  logic [63:0] m_data = '0;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  demux_router_reg u_dut (
    .clk(clk), .clr_n(clr_n), .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .drop_count(drop_count), .busy(busy)
  );

  demux_router_reg #(.CHANNELS(6)) u_dut6 (
    .clk(clk), .clr_n(clr_n), .in_data(d6_data), .in_sel(d6_sel), .in_bcast(d6_bcast),
    .in_valid(d6_valid), .in_ready(d6_ready), .out_data(d6_out_data), .out_valid(d6_out_valid),
    .out_ready(d6_out_ready), .drop_count(d6_drop), .busy(d6_busy)
  );

  task automatic cycle(input string name, input logic exp_acc);
    logic [7:0]  nv;
    logic [63:0] nd;
    sb_t         e;
    nv = m_valid;
    nd = m_data;
    for (int i = 0; i < 8; i++) begin
      if (exp_acc && (in_bcast || in_sel == i)) begin
        nv[i] = 1'b1;
        nd[i*8 +: 8] = in_data;
        sb.push_back('{i, in_data});
      end else if (out_ready[i]) nv[i] = 1'b0;
    end
    @(posedge clk); #1;
    m_valid = nv;
    m_data  = nd;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      tests++;
      if (out_data[e.ch*8 +: 8] !== e.d || out_valid[e.ch] !== 1'b1) begin
        fails++;
        $display("FAIL %s sb ch%0d: got data %h valid %b, want data %h valid 1", name, e.ch, out_data[e.ch*8 +: 8], out_valid[e.ch], e.d);
      end
    end
    tests++;
    if (out_valid !== m_valid) begin
      fails++;
      $display("FAIL %s out_valid: got %h want %h", name, out_valid, m_valid);
    end
    tests++;
    if (out_data !== m_data) begin
      fails++;
      $display("FAIL %s out_data: got %h want %h", name, out_data, m_data);
    end
    tests++;
    if (busy !== |m_valid) begin
      fails++;
      $display("FAIL %s busy: got %b want %b", name, busy, |m_valid);
    end
  endtask

  task automatic send(input logic [2:0] sel, input logic bcast, input logic [7:0] data, input logic exp_rdy, input string name);
    in_sel   = sel;
    in_bcast = bcast;
    in_data  = data;
    in_valid = 1'b1;
    #1;
    tests++;
    if (in_ready !== exp_rdy) begin
      fails++;
      $display("FAIL %s in_ready: got %b want %b", name, in_ready, exp_rdy);
    end
    cycle(name, exp_rdy);
    in_valid = 1'b0;
    in_bcast = 1'b0;
  endtask

  task automatic idle(input string name);
    in_valid = 1'b0;
    cycle(name, 1'b0);
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if (out_valid !== 8'h00 || out_data !== 64'h0 || drop_count !== 8'h00 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_init: got valid %h data %h drop %h busy %b, want all zero", out_valid, out_data, drop_count, busy);
    end
    @(negedge clk) clr_n = 1'b1;
    @(posedge clk); #1;
    d6_sel   = 3'd7;
    d6_valid = 1'b1;
    send(3'd0, 1'b0, 8'h01, 1'b1, "reset_ld0");
    d6_valid = 1'b0;
    tests++;
    if (d6_drop !== 8'd1) begin
      fails++;
      $display("FAIL reset_pre_drop: got %0d want 1", d6_drop);
    end
    send(3'd2, 1'b0, 8'h04, 1'b1, "reset_ld2");
    tests++;
    if (out_valid !== 8'h05) begin
      fails++;
      $display("FAIL reset_pre_valid: got %h want 05", out_valid);
    end
    in_sel   = 3'd1;
    in_data  = 8'h09;
    in_valid = 1'b1;
    #2 clr_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 8'h00 || out_data !== 64'h0 || busy !== 1'b0 || d6_drop !== 8'h00 || d6_out_valid !== 6'h00) begin
      fails++;
      $display("FAIL reset_async: got valid %h data %h busy %b drop6 %0d valid6 %h, want all zero", out_valid, out_data, busy, d6_drop, d6_out_valid);
    end
    in_valid = 1'b0;
    m_valid  = '0;
    m_data   = '0;
    sb.delete();
    @(negedge clk) clr_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unicast_sweep();
    for (int s = 0; s < 8; s++) send(3'(s), 1'b0, 8'h07, 1'b1, $sformatf("sweep_ch%0d", s));
    send(3'd3, 1'b0, 8'h55, 1'b0, "sweep_full_ch3");
    out_ready = 8'hFF;
    idle("sweep_drain_all");
    out_ready = 8'h00;
  endtask

  task automatic test_drain_refill();
    send(3'd2, 1'b0, 8'hA5, 1'b1, "refill_load");
    out_ready = 8'h04;
    send(3'd2, 1'b0, 8'h3C, 1'b1, "refill_same_cycle");
    out_ready = 8'h00;
    idle("refill_hold");
    out_ready = 8'h04;
    idle("refill_drain");
    out_ready = 8'h00;
  endtask

  task automatic test_retain();
    send(3'd4, 1'b0, 8'h11, 1'b1, "retain_load");
    out_ready = 8'h10;
    idle("retain_pulse");
    out_ready = 8'h00;
    idle("retain_after");
  endtask

  task automatic test_bcast_stall();
    send(3'd5, 1'b0, 8'h22, 1'b1, "bcast_fill5");
    send(3'd0, 1'b1, 8'hFF, 1'b0, "bcast_stall1");
    send(3'd6, 1'b1, 8'hFF, 1'b0, "bcast_stall2");
    out_ready = 8'h20;
    send(3'd1, 1'b1, 8'hFF, 1'b1, "bcast_go");
    out_ready = 8'h00;
    tests++;
    if (out_valid !== 8'hFF) begin
      fails++;
      $display("FAIL bcast_all_valid: got %h want ff", out_valid);
    end
    out_ready = 8'hFF;
    idle("bcast_drain");
    out_ready = 8'h00;
  endtask

  task automatic test_back_to_back();
    out_ready = 8'hFF;
    for (int s = 0; s < 8; s++) send(3'(7 - s), 1'b0, 8'(8'h80 + s), 1'b1, $sformatf("b2b_%0d", s));
    send(3'd0, 1'b0, 8'hC3, 1'b1, "b2b_reload0");
    idle("b2b_drain");
    out_ready = 8'h00;
  endtask

  task automatic test_drop();
    int exp;
    d6_sel   = 3'd6;
    d6_valid = 1'b1;
    #1;
    tests++;
    if (d6_ready !== 1'b1) begin
      fails++;
      $display("FAIL drop_sel6_ready: got %b want 1", d6_ready);
    end
    @(posedge clk); #1;
    tests++;
    if (d6_drop !== 8'd1 || d6_out_valid !== 6'h00) begin
      fails++;
      $display("FAIL drop_sel6: got drop %0d valid %h, want 1 and 00", d6_drop, d6_out_valid);
    end
    exp = 1;
    d6_sel = 3'd7;
    for (int c = 0; c < 300; c++) begin
      #1;
      tests++;
      if (d6_ready !== 1'b1) begin
        fails++;
        $display("FAIL drop_ready c%0d: got %b want 1", c, d6_ready);
      end
      @(posedge clk); #1;
      exp = (exp < 255) ? exp + 1 : 255;
      tests++;
      if (d6_drop !== 8'(exp) || d6_out_valid !== 6'h00) begin
        fails++;
        $display("FAIL drop_count c%0d: got %0d valid %h, want %0d and 00", c, d6_drop, d6_out_valid, exp);
      end
    end
    d6_valid = 1'b0;
    tests++;
    if (d6_drop !== 8'd255) begin
      fails++;
      $display("FAIL drop_saturated: got %0d want 255", d6_drop);
    end
  endtask

  initial begin
    test_reset();
    test_unicast_sweep();
    test_drain_refill();
    test_retain();
    test_bcast_stall();
    test_back_to_back();
    test_drop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
